// File: rtl/pulse_train_pkg.sv
// Shared definitions for the pulse train generator: state encoding and default widths.
package pulse_train_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int NUM_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

endpackage

// File: rtl/pulse_train_gen_phase_counter.sv
// Loadable down-counter that times one phase; holds at zero once expired.
module phase_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: N high/low pairs with programmable phase widths, busy and done strobe.
// Define PULSE_TRAIN_CONTINUOUS_EN to add the `continuous` input for seamless train repetition.
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int NUM_W = NUM_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NUM_W-1:0] num_pulses,
`ifdef PULSE_TRAIN_CONTINUOUS_EN
  input  logic             continuous,
`endif
  output logic             signal,
  output logic             busy,
  output logic             done
);

  // Counter load value for a phase of `len` cycles; a zero length behaves as one cycle.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] lo_q, lo_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
  logic [NUM_W-1:0] num_q, num_d;
`endif
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ld;
  logic [CNT_W-1:0] ld_val;
  logic             ph_zero;

  phase_counter #(.W(CNT_W)) u_phase (
    .clock (clock),
    .reset (reset),
    .load  (ld),
    .value (ld_val),
    .zero  (ph_zero)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pcnt_d  = pcnt_q;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    num_d   = num_q;
`endif
    done_d  = 1'b0;
    ld      = 1'b0;
    ld_val  = phase_load(hi_q);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_pulses != '0) begin
            // The first high phase loads straight from the inputs, the shadows fill in parallel.
            hi_d    = high_len;
            lo_d    = low_len;
            pcnt_d  = num_pulses;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
            num_d   = num_pulses;
`endif
            ld      = 1'b1;
            ld_val  = phase_load(high_len);
            state_d = ST_HIGH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (ph_zero) begin
          ld      = 1'b1;
          ld_val  = phase_load(lo_q);
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        if (ph_zero) begin
          if (pcnt_q > NUM_W'(1)) begin
            pcnt_d  = pcnt_q - 1'b1;
            ld      = 1'b1;
            state_d = ST_HIGH;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
          end else if (continuous) begin
            pcnt_d  = num_q;
            ld      = 1'b1;
            done_d  = 1'b1;
            state_d = ST_HIGH;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    signal_d = (state_d == ST_HIGH);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcnt_q   <= pcnt_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Shadow copies of the train parameters only change on an accepted start.
  always_ff @(posedge clock) begin
    hi_q  <= hi_d;
    lo_q  <= lo_d;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    num_q <= num_d;
`endif
  end

  assign signal = signal_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen against a waveform-list reference model.
module tb_pulse_train_gen;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] high_len;
  logic [7:0] low_len;
  logic [3:0] num_pulses;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
  logic       continuous;
`endif
  logic       signal;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  pulse_train_gen #(.CNT_W(8), .NUM_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .high_len   (high_len),
    .low_len    (low_len),
    .num_pulses (num_pulses),
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    .continuous (continuous),
`endif
    .signal     (signal),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic s, input logic b, input logic d);
    chk({tag, ".signal"}, signal, s);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, d);
  endtask

  task automatic idle_cycle();
    start = 1'b0;
    @(negedge clock);
    check_out("idle", 1'b0, 1'b0, 1'b0);
  endtask

  // Starts a train at the current negedge and follows it to the done cycle.
  // disturb_at: cycle where start is re-pulsed with high_len=7; abort_at: cycle after which reset hits.
  task automatic train(input int h, input int l, input int n, input int disturb_at, input int abort_at);
    bit wave[$];
    int he = (h == 0) ? 1 : h;
    int le = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < he; i++) wave.push_back(1'b1);
      for (int i = 0; i < le; i++) wave.push_back(1'b0);
    end
    start      = 1'b1;
    high_len   = 8'(h);
    low_len    = 8'(l);
    num_pulses = 4'(n);
    @(negedge clock);
    for (int j = 0; j < wave.size(); j++) begin
      check_out($sformatf("train h=%0d l=%0d n=%0d c=%0d", h, l, n, j), wave[j], 1'b1, 1'b0);
      if (j == abort_at) begin
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_out("abort", 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        check_out("abort_next", 1'b0, 1'b0, 1'b0);
        return;
      end
      high_len   = 8'($urandom);
      low_len    = 8'($urandom);
      num_pulses = 4'($urandom);
      start      = (j == disturb_at);
      if (j == disturb_at) high_len = 8'd7;
      @(negedge clock);
    end
    start = 1'b0;
    check_out($sformatf("train_done h=%0d l=%0d n=%0d", h, l, n), 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    high_len   = '0;
    low_len    = '0;
    num_pulses = '0;
`ifdef PULSE_TRAIN_CONTINUOUS_EN
    continuous = 1'b0;
`endif
    repeat (3) @(negedge clock);
    check_out("reset", 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    idle_cycle();

    train(3, 3, 3, -1, -1);
    idle_cycle();
    train(0, 5, 2, -1, -1);
    idle_cycle();

    start      = 1'b1;
    num_pulses = 4'd0;
    high_len   = 8'd3;
    @(negedge clock);
    start = 1'b0;
    check_out("zero_n", 1'b0, 1'b0, 1'b1);
    @(negedge clock);
    check_out("zero_n_next", 1'b0, 1'b0, 1'b0);
    idle_cycle();

    train(2, 2, 4, 5, -1);
    idle_cycle();
    idle_cycle();

    train(4, 4, 3, -1, 9);
    train(4, 4, 3, -1, -1);
    idle_cycle();

    train(255, 1, 1, -1, -1);
    train(1, 1, 15, -1, -1);
    idle_cycle();

    repeat (10) begin
      train($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(1, 5), -1, -1);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

`ifdef PULSE_TRAIN_CONTINUOUS_EN
    continuous = 1'b1;
    start      = 1'b1;
    high_len   = 8'd1;
    low_len    = 8'd1;
    num_pulses = 4'd2;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 4; j++) begin
        check_out($sformatf("cont t=%0d c=%0d", c, j), (j % 2) == 0, 1'b1, (c > 0) && (j == 0));
        if (c == 2 && j == 0) continuous = 1'b0;
        @(negedge clock);
      end
    end
    check_out("cont_done", 1'b0, 1'b0, 1'b1);
    idle_cycle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
